// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param.
// The bench or parent drives through master; the counter attaches as slave.
interface updown_counter_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             chnge;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             flag_clr;
  logic [WIDTH-1:0] out;
  logic             wrap;
  logic             ovf;
  logic             udf;

  modport master (
    output en, chnge, load, load_val, flag_clr,
    input  out, wrap, ovf, udf
  );

  modport slave (
    input  en, chnge, load, load_val, flag_clr,
    output out, wrap, ovf, udf
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with load, wrap-or-saturate terminal behaviour,
// a one-cycle boundary pulse and sticky overflow/underflow flags.
module updown_counter_param #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic                 CLK,
  input  logic                 reset,
  updown_counter_param_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] out_q,  out_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q,  ovf_d;
  logic             udf_q,  udf_d;

  logic             up_evt_s;
  logic             dn_evt_s;
  logic [WIDTH-1:0] load_clamp_s;

  // Next count and boundary-event detection; load outranks counting and never raises events.
  always_comb begin
    up_evt_s     = 1'b0;
    dn_evt_s     = 1'b0;
    out_d        = out_q;
    load_clamp_s = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    if (bus.load) begin
      out_d = load_clamp_s;
    end else if (bus.en) begin
      if (bus.chnge) begin
        if (out_q == MAX_VAL) begin
          up_evt_s = 1'b1;
          out_d    = SATURATE ? MAX_VAL : ZERO;
        end else begin
          out_d = out_q + ONE;
        end
      end else begin
        if (out_q == ZERO) begin
          dn_evt_s = 1'b1;
          out_d    = SATURATE ? ZERO : MAX_VAL;
        end else begin
          out_d = out_q - ONE;
        end
      end
    end else begin
      out_d = out_q;
    end
  end

  // Pulse and sticky flags; a set event on the same edge beats flag_clr.
  always_comb begin
    wrap_d = up_evt_s | dn_evt_s;
    if (up_evt_s) begin
      ovf_d = 1'b1;
    end else if (bus.flag_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (dn_evt_s) begin
      udf_d = 1'b1;
    end else if (bus.flag_clr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // State registers; reset clears everything, including a pulse that would otherwise fire.
  always_ff @(posedge CLK) begin
    if (reset) begin
      out_q  <= ZERO;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;
  assign bus.udf  = udf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: three counters (wrap MAX=9, saturate MAX=9, wrap MAX=1) share stimulus;
// each scenario pushes hand-derived expectations to a scoreboard and pops them after the edge.
module tb_updown_counter_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset_s;
  logic       en_s;
  logic       chnge_s;
  logic       load_s;
  logic [3:0] load_val_s;
  logic       flag_clr_s;

  updown_counter_param_if #(.WIDTH(4)) ifw ();
  updown_counter_param_if #(.WIDTH(4)) ifs ();
  updown_counter_param_if #(.WIDTH(4)) if1 ();

  assign ifw.en = en_s;  assign ifw.chnge = chnge_s;  assign ifw.load = load_s;
  assign ifw.load_val = load_val_s;  assign ifw.flag_clr = flag_clr_s;
  assign ifs.en = en_s;  assign ifs.chnge = chnge_s;  assign ifs.load = load_s;
  assign ifs.load_val = load_val_s;  assign ifs.flag_clr = flag_clr_s;
  assign if1.en = en_s;  assign if1.chnge = chnge_s;  assign if1.load = load_s;
  assign if1.load_val = load_val_s;  assign if1.flag_clr = flag_clr_s;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap9 (
    .CLK(CLK), .reset(reset_s), .bus(ifw));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat9 (
    .CLK(CLK), .reset(reset_s), .bus(ifs));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd1), .SATURATE(1'b0)) u_wrap1 (
    .CLK(CLK), .reset(reset_s), .bus(if1));

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       ch;
    logic       fc;
    logic [3:0] out;
    logic       wr;
    logic       ov;
    logic       ud;
  } row_t;

  typedef struct {
    int         dut;
    logic [6:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic row_t r(input int rst, input int ld, input int lv, input int en,
                             input int ch, input int fc, input int o, input int w,
                             input int ov, input int ud);
    row_t x;
    x.rst = rst[0]; x.ld = ld[0]; x.lv = lv[3:0]; x.en = en[0]; x.ch = ch[0];
    x.fc  = fc[0];  x.out = o[3:0]; x.wr = w[0]; x.ov = ov[0]; x.ud = ud[0];
    return x;
  endfunction

  function automatic logic [6:0] observe(input int d);
    case (d)
      0:       return {ifw.out, ifw.wrap, ifw.ovf, ifw.udf};
      1:       return {ifs.out, ifs.wrap, ifs.ovf, ifs.udf};
      default: return {if1.out, if1.wrap, if1.ovf, if1.udf};
    endcase
  endfunction

  task automatic send(input int d, input row_t x, input string nm);
    exp_t e;
    reset_s    = x.rst;
    load_s     = x.ld;
    load_val_s = x.lv;
    en_s       = x.en;
    chnge_s    = x.ch;
    flag_clr_s = x.fc;
    e.dut  = d;
    e.v    = {x.out, x.wr, x.ov, x.ud};
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [6:0] got;
    for (int d = 0; d < 3; d++) begin
      send(d, r(1, 1, 5, 1, 1, 1, 0, 0, 0, 0), "reset");
      @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++; got = observe(e.dut);
      if (got !== e.v)
        $display("FAIL %s[dut%0d]: got out/wrap/ovf/udf=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 e.name, d, got[6:3], got[2], got[1], got[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_up();
    row_t t[$]; exp_t e; logic [6:0] got;
    t.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++) t.push_back(r(0, 0, 0, 1, 1, 0, k, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 1, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 1, 0, 1, 0));
    foreach (t[i]) begin
      send(0, t[i], "wrap_up");
      @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++; got = observe(e.dut);
      if (got !== e.v)
        $display("FAIL %s[%0d]: got out/wrap/ovf/udf=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 e.name, i, got[6:3], got[2], got[1], got[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_down();
    row_t t[$]; exp_t e; logic [6:0] got;
    t.push_back(r(0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    t.push_back(r(0, 0, 0, 1, 0, 0, 9, 1, 1, 1));
    t.push_back(r(0, 0, 0, 1, 0, 0, 8, 0, 1, 1));
    t.push_back(r(0, 0, 0, 0, 1, 0, 8, 0, 1, 1));
    t.push_back(r(0, 1, 12, 0, 0, 0, 9, 0, 1, 1));
    foreach (t[i]) begin
      send(0, t[i], "wrap_down");
      @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++; got = observe(e.dut);
      if (got !== e.v)
        $display("FAIL %s[%0d]: got out/wrap/ovf/udf=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 e.name, i, got[6:3], got[2], got[1], got[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    row_t t[$]; exp_t e; logic [6:0] got;
    t.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(r(0, 1, 12, 0, 0, 0, 9, 0, 0, 0));
    for (int k = 0; k < 3; k++) t.push_back(r(0, 0, 0, 1, 1, 0, 9, 1, 1, 0));
    t.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 2; k++) t.push_back(r(0, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    t.push_back(r(0, 0, 0, 1, 1, 0, 1, 0, 1, 1));
    foreach (t[i]) begin
      send(1, t[i], "saturate");
      @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++; got = observe(e.dut);
      if (got !== e.v)
        $display("FAIL %s[%0d]: got out/wrap/ovf/udf=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 e.name, i, got[6:3], got[2], got[1], got[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_load_priority();
    row_t t[$]; exp_t e; logic [6:0] got;
    t.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(r(0, 1, 5, 1, 1, 0, 5, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 6, 0, 0, 0));
    t.push_back(r(0, 1, 9, 1, 1, 0, 9, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 0, 0, 8, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 9, 0, 0, 0));
    t.push_back(r(0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      send(0, t[i], "load_priority");
      @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++; got = observe(e.dut);
      if (got !== e.v)
        $display("FAIL %s[%0d]: got out/wrap/ovf/udf=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 e.name, i, got[6:3], got[2], got[1], got[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_flag_clr();
    row_t t[$]; exp_t e; logic [6:0] got;
    t.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(r(0, 1, 9, 0, 0, 0, 9, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 1, 0, 1, 1, 0));
    t.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 0, 1, 9, 1, 0, 1));
    t.push_back(r(0, 0, 0, 0, 0, 1, 9, 0, 0, 0));
    t.push_back(r(0, 0, 0, 0, 0, 0, 9, 0, 0, 0));
    foreach (t[i]) begin
      send(0, t[i], "flag_clr");
      @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++; got = observe(e.dut);
      if (got !== e.v)
        $display("FAIL %s[%0d]: got out/wrap/ovf/udf=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 e.name, i, got[6:3], got[2], got[1], got[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    row_t t[$]; exp_t e; logic [6:0] got;
    t.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(r(0, 1, 9, 0, 0, 0, 9, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 1, 0));
    t.push_back(r(0, 1, 9, 0, 0, 0, 9, 0, 1, 0));
    t.push_back(r(1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    foreach (t[i]) begin
      send(0, t[i], "reset_mid");
      @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++; got = observe(e.dut);
      if (got !== e.v)
        $display("FAIL %s[%0d]: got out/wrap/ovf/udf=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 e.name, i, got[6:3], got[2], got[1], got[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    row_t t[$]; exp_t e; logic [6:0] got;
    t.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(r(0, 1, 7, 0, 0, 0, 1, 0, 0, 0));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 1, 0));
    t.push_back(r(0, 0, 0, 1, 0, 0, 1, 1, 1, 1));
    t.push_back(r(0, 0, 0, 1, 1, 0, 0, 1, 1, 1));
    t.push_back(r(0, 0, 0, 1, 0, 0, 1, 1, 1, 1));
    t.push_back(r(0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    foreach (t[i]) begin
      send(2, t[i], "back_to_back");
      @(posedge CLK); #1;
      e = sb.pop_front(); n_chk++; got = observe(e.dut);
      if (got !== e.v)
        $display("FAIL %s[%0d]: got out/wrap/ovf/udf=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                 e.name, i, got[6:3], got[2], got[1], got[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      else n_pass++;
    end
  endtask

  initial begin
    reset_s    = 1'b1;
    en_s       = 1'b0;
    chnge_s    = 1'b0;
    load_s     = 1'b0;
    load_val_s = 4'd0;
    flag_clr_s = 1'b0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_priority();
    test_flag_clr();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 Parameter WIDTH, default 4: counter and load width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal (highest) count; legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 CLK  input  1  clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 en  input  1  count enable; 0 = hold.
REQ-008 chnge  input  1  direction; 1 = count up, 0 = count down.
REQ-009 load  input  1  single-cycle load strobe.
REQ-010 load_val  input  WIDTH  value written to out on load.
REQ-011 flag_clr  input  1  clears the sticky ovf/udf flags.
REQ-012 out  output  WIDTH  current count, registered.
REQ-013 wrap  output  1  registered one-cycle boundary-event pulse.
REQ-014 ovf  output  1  sticky flag: an up-count was attempted at MAX_VAL.
REQ-015 udf  output  1  sticky flag: a down-count was attempted at 0.

Function
REQ-016 Per-edge priority SHALL be: reset > load > en counting > hold.
REQ-017 On load, out SHALL become min(load_val, MAX_VAL) on the next edge, regardless of en and chnge.
REQ-018 A loaded value SHALL NOT generate wrap, ovf or udf.
REQ-019 With en=1, no load, chnge=1, out<MAX_VAL: out SHALL increment by 1.
REQ-020 With en=1, no load, chnge=0, out>0: out SHALL decrement by 1.
REQ-021 Up-event (en=1, chnge=1, out==MAX_VAL, no load): out SHALL become 0 if SATURATE=0, or stay MAX_VAL if SATURATE=1.
REQ-022 Down-event (en=1, chnge=0, out==0, no load): out SHALL become MAX_VAL if SATURATE=0, or stay 0 if SATURATE=1.
REQ-023 wrap SHALL be 1 for exactly the cycle after each up- or down-event, in both modes, and 0 otherwise.
REQ-024 Back-to-back events (e.g. MAX_VAL=1, continuous up-count in wrap mode) SHALL keep wrap high on each event cycle.
REQ-025 ovf SHALL set on the edge of an up-event; udf SHALL set on the edge of a down-event.
REQ-026 flag_clr=1 SHALL clear ovf and udf on the next edge.
REQ-027 When a set event and flag_clr coincide on the same edge, the set SHALL win.
REQ-028 Direction changes SHALL take effect on the same edge, with no dead cycle.
REQ-029 Arithmetic SHALL be WIDTH-bit unsigned; out SHALL never exceed MAX_VAL, including after load.
REQ-030 The block SHALL have no state beyond out, wrap, ovf and udf, and SHALL NOT use load-value change detection: only the load strobe loads.

Reset
REQ-031 While reset=1 at an edge, out, wrap, ovf and udf SHALL all be 0 after that edge, overriding load, en and flag_clr.
REQ-032 Asserting reset mid-count SHALL abort any pending wrap pulse.
REQ-033 Counting SHALL resume from 0 on the first edge with reset=0 and en=1.
REQ-034 Before the first reset, output values are undefined; the bench SHALL apply reset for at least 1 cycle.

Verification (WIDTH=4, MAX_VAL=9 unless noted)
REQ-035 Wrap mode, reset, en=1, chnge=1 for 11 cycles:
  - out runs 1..9, then 0, then 1;
  - wrap pulses once (cycle after 9->0); ovf=1.
REQ-036 Wrap mode, out=0, en=1, chnge=0:
  - out goes 9, 8;
  - wrap pulses once; udf=1; ovf unchanged.
REQ-037 SATURATE=1, load load_val=12:
  - out=9; up-count 3 cycles keeps out=9, wrap high for each of those 3 cycles, ovf=1;
  - down-count from 0 keeps out=0, udf=1.
REQ-038 load=1 with load_val=5, en=1, chnge=1 on the same edge:
  - out=5 (not 6), no wrap;
  - next enabled edge gives out=6.
REQ-039 Up-event at out=9 and flag_clr=1 on the same edge:
  - ovf=1;
  - flag_clr alone on the next edge gives ovf=0.
REQ-040 reset asserted on the edge where out=9 would wrap:
  - out=0, wrap=0, ovf=0, udf=0.
